// File: rtl/mulacc_pkg.sv
// Shared types and constants for the round-robin multiply-accumulate scheduler.
package mulacc_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam int ACC_INIT = 1;

  // Context ids need at least one bit even for degenerate requester counts.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mulacc_dp.sv
// Registered unsigned WIDTH x WIDTH multiplier; the product is held until the next load.
module mulacc_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             hi_nz
);

  logic [2*WIDTH-1:0] prod_d, prod_q;

  always_comb begin
    prod_d = prod_q;
    if (load) begin
      prod_d = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign lo    = prod_q[WIDTH-1:0];
  assign hi    = prod_q[2*WIDTH-1:WIDTH];
  assign hi_nz = |prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mulacc_sched.sv
// Round-robin scheduler sharing one multiply datapath among NREQ accumulator contexts.
//   state | meaning
//   ARB   | pick next requester from rr_ptr, launch multiply (or note a clear)
//   EXEC  | write back product or init value into the granted context
module mulacc_sched
  import mulacc_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_clr,
  input  logic [NREQ*WIDTH-1:0] req_x,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ*WIDTH-1:0] acc_out,
  output logic [NREQ-1:0]       ovf_out,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  state_e           state_d, state_q;
  logic [IDW-1:0]   rr_ptr_d, rr_ptr_q;
  logic [IDW-1:0]   cur_id_d, cur_id_q;
  logic             clr_d, clr_q;
  logic [WIDTH-1:0] acc_d [NREQ];
  logic [WIDTH-1:0] acc_q [NREQ];
  logic [NREQ-1:0]  ovf_d, ovf_q;

  logic [WIDTH-1:0] x_arr [NREQ];
  logic [IDW-1:0]   winner, cand;
  logic             found;
  int               sum;

  logic             dp_load;
  logic [WIDTH-1:0] dp_lo, dp_hi;
  logic             dp_hi_nz;

  for (genvar i = 0; i < NREQ; i++) begin : g_ctx
    assign x_arr[i]                   = req_x[i*WIDTH +: WIDTH];
    assign acc_out[i*WIDTH +: WIDTH]  = acc_q[i];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    sum    = 0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      cand = IDW'(sum);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  mulacc_dp #(.WIDTH(WIDTH)) u_dp (
    .clk   (clk),
    .reset (reset),
    .load  (dp_load),
    .a     (acc_q[winner]),
    .b     (x_arr[winner]),
    .lo    (dp_lo),
    .hi    (dp_hi),
    .hi_nz (dp_hi_nz)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cur_id_d  = cur_id_q;
    clr_d     = clr_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    req_ready = '0;
    dp_load   = 1'b0;
    case (state_q)
      ARB: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          cur_id_d          = winner;
          clr_d             = req_clr[winner];
          dp_load           = !req_clr[winner];
          state_d           = EXEC;
        end
      end
      EXEC: begin
        if (clr_q) begin
          acc_d[cur_id_q] = WIDTH'(ACC_INIT);
          ovf_d[cur_id_q] = 1'b0;
        end else begin
          acc_d[cur_id_q] = dp_lo;
          ovf_d[cur_id_q] = ovf_q[cur_id_q] | dp_hi_nz;
        end
        rr_ptr_d = (cur_id_q == IDW'(NREQ-1)) ? '0 : cur_id_q + 1'b1;
        state_d  = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      clr_q    <= 1'b0;
      ovf_q    <= '0;
      for (int i = 0; i < NREQ; i++) begin
        acc_q[i] <= WIDTH'(ACC_INIT);
      end
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_id_q <= cur_id_d;
      clr_q    <= clr_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
    end
  end

  assign busy     = (state_q == EXEC);
  assign grant_id = (state_q == EXEC) ? cur_id_q : '0;
  assign ovf_out  = ovf_q;

  // The overflow decision relies on hi_nz summarising the upper product half.
  hi_nz_consistent : assert property (@(posedge clk) disable iff (reset)
    dp_hi_nz == (dp_hi != '0));

endmodule

// File: tb/tb_mulacc_sched.sv
// Scenario-driven bench for mulacc_sched with a scoreboard of expected context images.
module tb_mulacc_sched;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct {
    int          id;
    logic [31:0] acc;
    logic [3:0]  ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_clr = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] acc_out;
  logic [N-1:0]  ovf_out;
  logic          busy;
  logic [1:0]    grant_id;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic [7:0]  m_acc [N];
  logic [3:0]  m_ovf;
  int          m_rr;
  int          m_cur;
  logic        hs_prev;
  logic        busy_prev;

  mulacc_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_clr   (req_clr),
    .req_x     (req_x),
    .req_ready (req_ready),
    .acc_out   (acc_out),
    .ovf_out   (ovf_out),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  // Reference model: grants and context images predicted from the inputs alone.
  always @(negedge clk) begin
    logic [3:0]  exp_ready;
    logic [15:0] p;
    logic [7:0]  xv;
    int          w;
    exp_t        e;
    if (reset) begin
      sb.delete();
      for (int i = 0; i < N; i++) m_acc[i] = 8'h01;
      m_ovf     = '0;
      m_rr      = 0;
      m_cur     = 0;
      hs_prev   = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (busy_prev) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: write-back seen with no op outstanding");
        end else begin
          e = sb.pop_front();
          checks += 2;
          if (acc_out !== e.acc) begin
            errors++;
            $display("FAIL sb_acc id=%0d: got %h expected %h", e.id, acc_out, e.acc);
          end
          if (ovf_out !== e.ovf) begin
            errors++;
            $display("FAIL sb_ovf id=%0d: got %b expected %b", e.id, ovf_out, e.ovf);
          end
        end
      end
      checks++;
      if (busy !== hs_prev) begin
        errors++;
        $display("FAIL sb_busy: got %b expected %b", busy, hs_prev);
      end
      exp_ready = '0;
      w = -1;
      if (hs_prev) begin
        checks++;
        if (grant_id !== 2'(m_cur)) begin
          errors++;
          $display("FAIL sb_grant_id: got %0d expected %0d", grant_id, m_cur);
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        end
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL sb_ready: got %b expected %b", req_ready, exp_ready);
      end
      if (w >= 0) begin
        if (req_clr[w]) begin
          m_acc[w] = 8'h01;
          m_ovf[w] = 1'b0;
        end else begin
          xv = req_x[w*W +: W];
          p  = 16'(m_acc[w]) * 16'(xv);
          m_acc[w] = p[7:0];
          m_ovf[w] = m_ovf[w] | (p[15:8] != 8'h00);
        end
        e.id  = w;
        e.acc = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
        e.ovf = m_ovf;
        sb.push_back(e);
        m_cur = w;
        m_rr  = (w + 1) % N;
      end
      busy_prev = busy;
      hs_prev   = (w >= 0);
    end
  end

  task automatic pulse_reset(input int cycles);
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = '0;
    req_clr   = '0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issue one op and return once its write-back is visible.
  task automatic do_op(input int id, input logic [7:0] x, input logic clr);
    bit got = 0;
    @(posedge clk); #1;
    req_valid[id]       = 1'b1;
    req_clr[id]         = clr;
    req_x[id*W +: W]    = x;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL op_timeout id=%0d: got no grant expected grant within 40 cycles", id);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    req_clr[id]   = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    pulse_reset(2);
    @(negedge clk);
    checks += 5;
    if (acc_out !== 32'h01010101) begin errors++; $display("FAIL rst_acc: got %h expected 01010101", acc_out); end
    if (ovf_out !== 4'b0000) begin errors++; $display("FAIL rst_ovf: got %b expected 0000", ovf_out); end
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d expected 0", grant_id); end
  endtask

  task automatic test_accumulate;
    do_op(0, 8'd5, 1'b0);
    checks++;
    if (acc_out[7:0] !== 8'd5) begin errors++; $display("FAIL acc_x5: got %h expected 05", acc_out[7:0]); end
    do_op(0, 8'd7, 1'b0);
    checks += 2;
    if (acc_out[7:0] !== 8'h23) begin errors++; $display("FAIL acc_x7: got %h expected 23", acc_out[7:0]); end
    if (ovf_out[0] !== 1'b0) begin errors++; $display("FAIL acc_ovf0: got %b expected 0", ovf_out[0]); end
  endtask

  task automatic test_overflow;
    do_op(0, 8'd8, 1'b0);
    checks += 2;
    if (acc_out[7:0] !== 8'h18) begin errors++; $display("FAIL ovf_x8_acc: got %h expected 18", acc_out[7:0]); end
    if (ovf_out[0] !== 1'b1) begin errors++; $display("FAIL ovf_x8_flag: got %b expected 1", ovf_out[0]); end
    do_op(0, 8'd1, 1'b0);
    checks += 2;
    if (acc_out[7:0] !== 8'h18) begin errors++; $display("FAIL ovf_x1_acc: got %h expected 18", acc_out[7:0]); end
    if (ovf_out[0] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf_out[0]); end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_x     = {8'd5, 8'd4, 8'd3, 8'd2};
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks += 2;
      if (busy !== 1'(k % 2)) begin
        errors++;
        $display("FAIL b2b_busy k=%0d: got %b expected %0d", k, busy, k % 2);
      end
      if (k % 2 == 0) begin
        if (req_ready !== 4'(1 << ((k / 2) % N))) begin
          errors++;
          $display("FAIL b2b_ready k=%0d: got %b expected %b", k, req_ready, 4'(1 << ((k / 2) % N)));
        end
      end else if (grant_id !== 2'((k / 2) % N)) begin
        errors++;
        $display("FAIL b2b_grant k=%0d: got %0d expected %0d", k, grant_id, (k / 2) % N);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear;
    pulse_reset(1);
    do_op(1, 8'd3, 1'b0);
    do_op(2, 8'h90, 1'b0);
    do_op(2, 8'd3, 1'b0);
    checks += 2;
    if (acc_out[23:16] !== 8'hB0) begin errors++; $display("FAIL clr_pre_acc2: got %h expected b0", acc_out[23:16]); end
    if (ovf_out[2] !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf2: got %b expected 1", ovf_out[2]); end
    do_op(2, 8'd9, 1'b1);
    checks += 2;
    if (acc_out !== 32'h01010301) begin errors++; $display("FAIL clr_acc: got %h expected 01010301", acc_out); end
    if (ovf_out !== 4'b0000) begin errors++; $display("FAIL clr_ovf: got %b expected 0000", ovf_out); end
    do_op(3, 8'd0, 1'b0);
    do_op(3, 8'd5, 1'b0);
    checks += 2;
    if (acc_out !== 32'h00010301) begin errors++; $display("FAIL zero_acc: got %h expected 00010301", acc_out); end
    if (ovf_out !== 4'b0000) begin errors++; $display("FAIL zero_ovf: got %b expected 0000", ovf_out); end
  endtask

  task automatic test_reset_in_exec;
    bit got = 0;
    pulse_reset(1);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_x[15:8] = 8'd3;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rie_grant1: got no grant expected grant to req1"); end
    @(posedge clk); #1;
    reset      = 1'b1;
    req_valid  = 4'b0011;
    req_x[7:0] = 8'd2;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rie_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks += 3;
    if (acc_out !== 32'h01010101) begin errors++; $display("FAIL rie_acc: got %h expected 01010101", acc_out); end
    if (ovf_out !== 4'b0000) begin errors++; $display("FAIL rie_ovf: got %b expected 0000", ovf_out); end
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rie_next_grant: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (acc_out !== 32'h01010102) begin errors++; $display("FAIL rie_after: got %h expected 01010102", acc_out); end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_reset_in_exec();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
